// File: rtl/herald_cmd_sequencer.sv
// herald_cmd_sequencer
// Byte-serial command front-end between the pad wrapper and the compute engines.
// The host writes a command byte and up to two little-endian operands. The block
// then starts the engine, waits for its result (or aborts it on timeout) and
// returns the result bytes one per host read. Status and sticky error codes can
// be read back whenever no result is being streamed.
module herald_cmd_sequencer #(
    parameter int OP_BYTES    = 3,
    parameter int RES_BYTES   = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     ui_in,
    input  logic                           wr_strb,
    input  logic                           rd_strb,
    output logic [7:0]                     uo_out,
    output logic                           busy,
    output logic [1:0]                     err_code,
    output logic [7:0]                     cmd_code,
    input  logic                           cmd_known,
    input  logic [1:0]                     cmd_nargs,
    input  logic [$clog2(RES_BYTES+1)-1:0] cmd_res_bytes,
    output logic                           eng_start,
    output logic                           eng_abort,
    output logic [8*OP_BYTES-1:0]          eng_op_a,
    output logic [8*OP_BYTES-1:0]          eng_op_b,
    input  logic                           eng_done,
    input  logic [8*RES_BYTES-1:0]         eng_result
);

    localparam int OP_W  = 8 * OP_BYTES;
    localparam int RES_W = 8 * RES_BYTES;
    localparam int RL_W  = $clog2(RES_BYTES + 1);
    localparam int OB_W  = $clog2(OP_BYTES + 1);
    localparam int IDX_W = (RL_W > OB_W) ? RL_W : OB_W;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 2);

    localparam logic [IDX_W-1:0] OP_LAST  = IDX_W'(OP_BYTES - 1);
    localparam logic [RL_W-1:0]  RES_MAX  = RL_W'(RES_BYTES);
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ARG_A,
        S_ARG_B,
        S_EXEC,
        S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic               wr_prev_q, rd_prev_q;
    logic [RES_W-1:0]   res_q, res_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         nargs_q, nargs_d;
    logic [RL_W-1:0]    res_len_q, res_len_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;

    logic [7:0]         uo_out_d;
    logic               busy_d;
    logic [1:0]         err_d;
    logic [7:0]         cmd_d;
    logic               start_d, abort_d;
    logic [OP_W-1:0]    op_a_d, op_b_d;

    logic               wr_edge, rd_edge;
    logic [7:0]         status;
    logic [1:0]         dec_nargs;
    logic [RL_W-1:0]    dec_res;
    logic               take_cmd, go_exec;

    // A write edge always wins over a read edge arriving in the same cycle,
    // and the decoder's operand count / result length are clamped to what fits.
    always_comb begin
        wr_edge   = wr_strb & ~wr_prev_q;
        rd_edge   = rd_strb & ~rd_prev_q & ~wr_edge;
        status    = {busy, 5'b00000, err_code};
        dec_nargs = (cmd_nargs == 2'd3) ? 2'd2 : cmd_nargs;
        dec_res   = (cmd_res_bytes > RES_MAX) ? RES_MAX : cmd_res_bytes;
    end

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_d   = state_q;
        uo_out_d  = uo_out;
        busy_d    = busy;
        err_d     = err_code;
        cmd_d     = cmd_code;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        op_a_d    = eng_op_a;
        op_b_d    = eng_op_b;
        res_d     = res_q;
        idx_d     = idx_q;
        nargs_d   = nargs_q;
        res_len_d = res_len_q;
        tcnt_d    = tcnt_q;
        take_cmd  = 1'b0;
        go_exec   = 1'b0;

        if (rd_edge && state_q != S_RESULT) begin
            uo_out_d = status;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_edge) begin
                    take_cmd = 1'b1;
                end
            end

            S_DECODE: begin
                if (!cmd_known) begin
                    err_d   = ERR_UNKNOWN;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    nargs_d   = dec_nargs;
                    res_len_d = dec_res;
                    idx_d     = '0;
                    if (dec_nargs == 2'd0) begin
                        go_exec = 1'b1;
                    end else begin
                        state_d = S_ARG_A;
                    end
                end
            end

            S_ARG_A, S_ARG_B: begin
                if (wr_edge) begin
                    if (state_q == S_ARG_A) begin
                        op_a_d[{idx_q, 3'b000} +: 8] = ui_in;
                    end else begin
                        op_b_d[{idx_q, 3'b000} +: 8] = ui_in;
                    end
                    if (idx_q == OP_LAST) begin
                        if (state_q == S_ARG_A && nargs_q == 2'd2) begin
                            state_d = S_ARG_B;
                            idx_d   = '0;
                        end else begin
                            go_exec = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_EXEC: begin
                if (wr_edge) begin
                    err_d = ERR_OVERRUN;
                end
                if (eng_done && !eng_start) begin
                    res_d  = eng_result;
                    busy_d = 1'b0;
                    idx_d  = '0;
                    if (res_len_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESULT;
                    end
                end else if (TIMEOUT_CYC != 0 && tcnt_q == TO_LAST) begin
                    abort_d = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_RESULT: begin
                if (wr_edge) begin
                    take_cmd = 1'b1;
                end else if (rd_edge) begin
                    uo_out_d = res_q[{idx_q, 3'b000} +: 8];
                    if (idx_q + 1'b1 == IDX_W'(res_len_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_cmd) begin
            cmd_d   = ui_in;
            err_d   = ERR_NONE;
            busy_d  = 1'b1;
            op_a_d  = '0;
            op_b_d  = '0;
            state_d = S_DECODE;
        end

        if (go_exec) begin
            start_d = 1'b1;
            tcnt_d  = '0;
            state_d = S_EXEC;
        end
    end

    // State, edge-detect and output registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            uo_out    <= '0;
            busy      <= 1'b0;
            err_code  <= ERR_NONE;
            cmd_code  <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            eng_op_a  <= '0;
            eng_op_b  <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            nargs_q   <= '0;
            res_len_q <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_prev_q <= wr_strb;
            rd_prev_q <= rd_strb;
            uo_out    <= uo_out_d;
            busy      <= busy_d;
            err_code  <= err_d;
            cmd_code  <= cmd_d;
            eng_start <= start_d;
            eng_abort <= abort_d;
            eng_op_a  <= op_a_d;
            eng_op_b  <= op_b_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            nargs_q   <= nargs_d;
            res_len_q <= res_len_d;
            tcnt_q    <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_herald_cmd_sequencer.sv
// tb_herald_cmd_sequencer
// Drives host transactions against herald_cmd_sequencer with a table-driven
// command decoder and a behavioural engine, and predicts every observable
// result at transaction level (operands, start/abort timing, read bytes, errors).
module tb_herald_cmd_sequencer;

    localparam int OP_BYTES    = 3;
    localparam int RES_BYTES   = 9;
    localparam int TIMEOUT_CYC = 16;

    typedef struct packed {
        logic       known;
        logic [1:0] nargs;
        logic [3:0] res;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ui_in = '0;
    logic        wr_strb = 1'b0;
    logic        rd_strb = 1'b0;
    logic [7:0]  uo_out;
    logic        busy;
    logic [1:0]  err_code;
    logic [7:0]  cmd_code;
    logic        cmd_known;
    logic [1:0]  cmd_nargs;
    logic [3:0]  cmd_res_bytes;
    logic        eng_start;
    logic        eng_abort;
    logic [23:0] eng_op_a;
    logic [23:0] eng_op_b;
    logic        eng_done = 1'b0;
    logic [71:0] eng_result = '0;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          startCount = 0;
    int          abortCount = 0;
    int          startCycle = 0;
    int          abortCycle = 0;
    logic [23:0] capA = '0;
    logic [23:0] capB = '0;
    int          engDelay = 0;
    int          engRemain = 0;
    bit          engEarly = 1'b0;
    logic [71:0] engValue = '0;

    logic [7:0]  pendingRes[$];
    logic [1:0]  modelErr = 2'd0;
    logic [7:0]  lastUo = 8'h00;
    logic [7:0]  cmdPool[8] = '{8'h20, 8'h13, 8'h22, 8'h31, 8'h33, 8'h40, 8'h41, 8'h7E};
    dec_t        liveDec;

    herald_cmd_sequencer #(
        .OP_BYTES   (OP_BYTES),
        .RES_BYTES  (RES_BYTES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ui_in        (ui_in),
        .wr_strb      (wr_strb),
        .rd_strb      (rd_strb),
        .uo_out       (uo_out),
        .busy         (busy),
        .err_code     (err_code),
        .cmd_code     (cmd_code),
        .cmd_known    (cmd_known),
        .cmd_nargs    (cmd_nargs),
        .cmd_res_bytes(cmd_res_bytes),
        .eng_start    (eng_start),
        .eng_abort    (eng_abort),
        .eng_op_a     (eng_op_a),
        .eng_op_b     (eng_op_b),
        .eng_done     (eng_done),
        .eng_result   (eng_result)
    );

    always #5 clk = ~clk;

    // External command decoder table: known flag, raw operand count, raw result length.
    function automatic dec_t decodeTable(input logic [7:0] c);
        dec_t d;
        d = '0;
        case (c)
            8'h20:   d = '{1'b1, 2'd2, 4'd3};
            8'h13:   d = '{1'b1, 2'd2, 4'd9};
            8'h22:   d = '{1'b1, 2'd0, 4'd0};
            8'h31:   d = '{1'b1, 2'd1, 4'd2};
            8'h33:   d = '{1'b1, 2'd3, 4'd15};
            8'h40:   d = '{1'b1, 2'd1, 4'd12};
            8'h41:   d = '{1'b1, 2'd0, 4'd1};
            default: d = '0;
        endcase
        return d;
    endfunction

    assign liveDec       = decodeTable(cmd_code);
    assign cmd_known     = liveDec.known;
    assign cmd_nargs     = liveDec.nargs;
    assign cmd_res_bytes = liveDec.res;

    function automatic logic [71:0] randRes();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[71:0];
    endfunction

    // Behavioural engine and event monitor, evaluated just after each rising edge.
    always @(posedge clk) begin
        #1;
        cycle++;
        if (eng_start) begin
            startCount++;
            startCycle = cycle;
            capA       = eng_op_a;
            capB       = eng_op_b;
            engRemain  = engDelay;
            eng_done   = engEarly;
            eng_result = randRes();
        end else if (engRemain > 0) begin
            engRemain--;
            eng_done   = (engRemain == 0);
            eng_result = (engRemain == 0) ? engValue : randRes();
        end else begin
            eng_done = 1'b0;
        end
        if (eng_abort) begin
            abortCount++;
            abortCycle = cycle;
            engRemain  = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hostWrite(input logic [7:0] b);
        ui_in   = b;
        wr_strb = 1'b1;
        @(negedge clk);
        wr_strb = 1'b0;
        @(negedge clk);
    endtask

    task automatic hostWriteRead(input logic [7:0] b);
        ui_in   = b;
        wr_strb = 1'b1;
        rd_strb = 1'b1;
        @(negedge clk);
        wr_strb = 1'b0;
        rd_strb = 1'b0;
        @(negedge clk);
    endtask

    task automatic hostRead(output logic [7:0] v);
        rd_strb = 1'b1;
        @(negedge clk);
        v       = uo_out;
        rd_strb = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitStart(input int prev);
        int n;
        n = 0;
        while (startCount == prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("start_count", 72'(startCount), 72'(prev + 1));
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_clear", 72'(busy), 72'(0));
    endtask

    // One complete host command: write, operands, engine run, then nReads reads.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] opA, input logic [23:0] opB,
                                 input int delay, input bit early, input bit overrun,
                                 input int nReads, input bit sim, input bit peek);
        dec_t        d;
        int          effN, effR, prevStart, prevAbort, markCycle;
        logic [7:0]  v, expByte, opByte;
        logic [23:0] expA, expB;
        logic [71:0] value;

        d         = decodeTable(cmd);
        effN      = (d.nargs == 2'd3) ? 2 : int'(d.nargs);
        effR      = (d.res > 4'd9) ? 9 : int'(d.res);
        value     = randRes();
        engValue  = value;
        engDelay  = delay;
        engEarly  = early;
        prevStart = startCount;
        prevAbort = abortCount;
        markCycle = cycle;

        if (sim) begin
            hostWriteRead(cmd);
            checkOutput("simul_uo_hold", 72'(uo_out), 72'(lastUo));
        end else begin
            hostWrite(cmd);
        end
        pendingRes.delete();
        checkOutput("cmd_code", 72'(cmd_code), 72'(cmd));

        if (!d.known) begin
            modelErr = 2'd1;
            checkOutput("unknown_busy", 72'(busy), 72'(0));
            checkOutput("unknown_nostart", 72'(startCount), 72'(prevStart));
        end else begin
            modelErr = 2'd0;
            checkOutput("busy_set", 72'(busy), 72'(1));
            expA = (effN >= 1) ? opA : 24'h0;
            expB = (effN >= 2) ? opB : 24'h0;
            for (int k = 0; k < effN; k++) begin
                for (int j = 0; j < OP_BYTES; j++) begin
                    opByte = (k == 0) ? opA[j*8 +: 8] : opB[j*8 +: 8];
                    if (peek && j == 1) begin
                        hostRead(v);
                        checkOutput("arg_status", 72'(v), 72'(8'h80));
                        lastUo = 8'h80;
                    end
                    markCycle = cycle;
                    hostWrite(opByte);
                end
            end
            waitStart(prevStart);
            checkOutput("start_latency", 72'(startCycle - markCycle), 72'((effN == 0) ? 2 : 1));
            checkOutput("op_a", 72'(capA), 72'(expA));
            checkOutput("op_b", 72'(capB), 72'(expB));
            if (overrun) begin
                hostWrite(8'($urandom()));
                modelErr = 2'd3;
            end
            waitIdle();
            if (delay == 0 || delay >= TIMEOUT_CYC) begin
                modelErr = 2'd2;
                checkOutput("abort_count", 72'(abortCount), 72'(prevAbort + 1));
                checkOutput("abort_time", 72'(abortCycle - startCycle), 72'(TIMEOUT_CYC));
            end else begin
                checkOutput("abort_none", 72'(abortCount), 72'(prevAbort));
                for (int j = 0; j < effR; j++) begin
                    pendingRes.push_back(value[8*j +: 8]);
                end
            end
            checkOutput("start_once", 72'(startCount), 72'(prevStart + 1));
        end
        checkOutput("err_code", 72'(err_code), 72'(modelErr));

        for (int r = 0; r < nReads; r++) begin
            hostRead(v);
            if (pendingRes.size() > 0) begin
                expByte = pendingRes.pop_front();
            end else begin
                expByte = {6'b000000, modelErr};
            end
            checkOutput("read_byte", 72'(v), 72'(expByte));
            lastUo = expByte;
        end
    endtask

    // Reset values, directed scenarios, reset mid-execution, then randomized traffic.
    initial begin
        int prevStart, prevAbort, effR, nr;
        logic [7:0] v;
        dec_t d;

        repeat (3) @(negedge clk);
        checkOutput("rst_uo_out", 72'(uo_out), 72'(0));
        checkOutput("rst_busy", 72'(busy), 72'(0));
        checkOutput("rst_err", 72'(err_code), 72'(0));
        checkOutput("rst_cmd", 72'(cmd_code), 72'(0));
        checkOutput("rst_start", 72'(eng_start), 72'(0));
        checkOutput("rst_abort", 72'(eng_abort), 72'(0));
        checkOutput("rst_op_a", 72'(eng_op_a), 72'(0));
        checkOutput("rst_op_b", 72'(eng_op_b), 72'(0));
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'h20, 24'h001000, 24'h002000, 5, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        applyStimulus(8'h13, 24'hABCDEF, 24'h123456, 7, 1'b0, 1'b0, 10, 1'b0, 1'b1);
        applyStimulus(8'h22, 24'h0, 24'h0, 3, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(8'h7E, 24'h0, 24'h0, 3, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(8'h41, 24'h0, 24'h0, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(8'h31, 24'h5A5A5A, 24'h0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(8'h22, 24'h0, 24'h0, 10, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        applyStimulus(8'h20, 24'h010203, 24'h040506, 4, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        applyStimulus(8'h20, 24'h0A0B0C, 24'h0D0E0F, 6, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        applyStimulus(8'h41, 24'h0, 24'h0, 3, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        applyStimulus(8'h33, 24'h111111, 24'h222222, 15, 1'b0, 1'b0, 10, 1'b0, 1'b0);

        prevStart = startCount;
        prevAbort = abortCount;
        engDelay  = 10;
        engEarly  = 1'b0;
        engValue  = randRes();
        hostWrite(8'h22);
        waitStart(prevStart);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 72'(busy), 72'(0));
        checkOutput("midrst_uo", 72'(uo_out), 72'(0));
        checkOutput("midrst_cmd", 72'(cmd_code), 72'(0));
        repeat (14) @(negedge clk);
        checkOutput("midrst_starts", 72'(startCount), 72'(prevStart + 1));
        checkOutput("midrst_aborts", 72'(abortCount), 72'(prevAbort));
        checkOutput("midrst_idle", 72'(busy), 72'(0));
        hostRead(v);
        checkOutput("midrst_status", 72'(v), 72'(8'h00));
        lastUo   = 8'h00;
        modelErr = 2'd0;
        pendingRes.delete();

        for (int t = 0; t < 60; t++) begin
            logic [7:0] c;
            c    = cmdPool[$urandom_range(0, 7)];
            d    = decodeTable(c);
            effR = (d.res > 4'd9) ? 9 : int'(d.res);
            nr   = $urandom_range(0, effR + 1);
            applyStimulus(c, 24'($urandom()), 24'($urandom()), $urandom_range(0, 22),
                          ($urandom() % 4) == 0, ($urandom() % 5) == 0, nr,
                          ($urandom() % 4) == 0, ($urandom() % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung handshake.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
